clint_dev: RTL and testbench

Core-local interruptor (CLINT) for the 5-stage RV64 core. It decodes data-memory accesses from the memory stage that fall in the CLINT window. It holds `msip`, `mtime` and `mtimecmp`, advances `mtime` through a prescaler, and drives the software and timer interrupt lines toward the CSR/trap logic. It sits beside the RAM helper on the memory-stage data port, and the core muxes read data by `hit`.

---
 rtl/clint_dev_pkg.sv | 39 +++
 rtl/clint_dev_if.sv | 26 ++
 rtl/clint_tick_gen.sv | 30 +++
 rtl/clint_dev.sv | 103 ++++++++++
 tb/tb_clint_dev.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clint_dev_pkg.sv
// CLINT shared definitions: window base, register offsets, select encoding, masked-write helper.
// Shared with the memory-stage address decode so both sides agree on the map.
// No logic state lives here.
package clint_dev_pkg;

  localparam int XLEN = 64;

  localparam logic [63:0] CLINT_BASE         = 64'h0000_0000_0200_0000;
  localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_MTIMECMP,
    SEL_MTIME
  } clint_sel_e;

  // Map a doubleword-aligned window offset to the register it names.
  function automatic clint_sel_e decode_sel(input logic [15:0] off);
    clint_sel_e sel;
    case (off)
      CLINT_MSIP_OFF:     sel = SEL_MSIP;
      CLINT_MTIMECMP_OFF: sel = SEL_MTIMECMP;
      CLINT_MTIME_OFF:    sel = SEL_MTIME;
      default:            sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  // Bit-masked merge of lane-shifted store data into an existing register.
  function automatic logic [XLEN-1:0] mask_merge(input logic [XLEN-1:0] old_val,
                                                 input logic [XLEN-1:0] wdata,
                                                 input logic [XLEN-1:0] wmask);
    return (old_val & ~wmask) | (wdata & wmask);
  endfunction

endpackage

// File: rtl/clint_dev_if.sv
// Memory-stage data port as seen by the CLINT: request, combinational hit, registered read response.
// Read response arrives one cycle after a read hit; stores complete silently.
// No backpressure: every hit is accepted in the cycle it is presented.
interface clint_dev_if;
  import clint_dev_pkg::*;

  logic            req_valid;
  logic            req_wen;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [XLEN-1:0] req_wmask;
  logic            hit;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask,
    input  hit, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask,
    output hit, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/clint_tick_gen.sv
// mtime prescaler: div_cnt counts 0..TICK_DIV-1 and wraps; tick is high on the last count.
// Latency: tick is decoded straight from the counter register (no extra delay).
// No backpressure: free-running.
module clint_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  logic [15:0] div_cnt_q;
  logic [15:0] div_cnt_d;

  assign tick = (div_cnt_q == TICK_LAST);

  // Advance the prescaler, wrapping to zero on the tick cycle.
  always_comb begin
    div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
  end

  // Prescaler state, cleared by synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) div_cnt_q <= 16'd0;
    else       div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/clint_dev.sv
// Core-local interruptor: msip / mtimecmp / mtime registers on the memory-stage data port.
// Latency: hit is combinational, read data 1 cycle, writes take effect at the request edge.
// No backpressure: a read or write can be accepted every cycle.
module clint_dev
  import clint_dev_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = CLINT_BASE,
  parameter int          TICK_DIV  = 1
) (
  input  logic        clock,
  input  logic        reset,
  clint_dev_if.slave  bus,
  output logic        sw_irq,
  output logic        timer_irq
);

  logic            tick;
  logic [15:0]     req_off;
  clint_sel_e      req_sel;
  logic            wr_en;
  logic            rd_en;
  logic [XLEN-1:0] rd_val;
  logic [2:0]      unused_addr_lsb;

  logic            msip_q,      msip_d;
  logic [XLEN-1:0] mtime_q,     mtime_d;
  logic [XLEN-1:0] mtimecmp_q,  mtimecmp_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            timer_irq_q, timer_irq_d;

  clint_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // Window decode: upper 48 address bits select the CLINT, [15:3] picks the doubleword.
  assign bus.hit         = bus.req_valid && (bus.req_addr[63:16] == BASE_ADDR[63:16]);
  assign req_off         = {bus.req_addr[15:3], 3'b000};
  assign req_sel         = decode_sel(req_off);
  assign wr_en           = bus.hit && bus.req_wen;
  assign rd_en           = bus.hit && !bus.req_wen;
  assign unused_addr_lsb = bus.req_addr[2:0];

  // Register updates: a store to mtime overrides the prescaler increment in the same cycle.
  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr_en) begin
      case (req_sel)
        SEL_MSIP:     msip_d     = (msip_q & ~bus.req_wmask[0]) | (bus.req_wdata[0] & bus.req_wmask[0]);
        SEL_MTIMECMP: mtimecmp_d = mask_merge(mtimecmp_q, bus.req_wdata, bus.req_wmask);
        SEL_MTIME:    mtime_d    = mask_merge(mtime_q, bus.req_wdata, bus.req_wmask);
        default:      ;
      endcase
    end
  end

  // Read mux on pre-update register values; unmapped offsets read zero.
  always_comb begin
    rd_val = '0;
    case (req_sel)
      SEL_MSIP:     rd_val = {{(XLEN-1){1'b0}}, msip_q};
      SEL_MTIMECMP: rd_val = mtimecmp_q;
      SEL_MTIME:    rd_val = mtime_q;
      default:      rd_val = '0;
    endcase
  end

  // Response pipeline and timer compare; read data holds between reads.
  always_comb begin
    rsp_valid_d = rd_en;
    rsp_rdata_d = rd_en ? rd_val : rsp_rdata_q;
    timer_irq_d = (mtime_q >= mtimecmp_q);
  end

  // All CLINT state, cleared by synchronous reset (drops any pending response).
  always_ff @(posedge clock) begin
    if (reset) begin
      msip_q      <= 1'b0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      timer_irq_q <= 1'b0;
    end else begin
      msip_q      <= msip_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      timer_irq_q <= timer_irq_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign sw_irq        = msip_q;
  assign timer_irq     = timer_irq_q;

endmodule

// File: tb/tb_clint_dev.sv
// Bench for clint_dev: two instances (TICK_DIV=1 and 4) share one stimulus stream.
// A cycle-level behavioural model tracks cycles since reset and derives ticks arithmetically.
// Directed scenarios first, then a randomized run.
module tb_clint_dev;

  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
  localparam logic [63:0] OFF_MSIP = 64'h0000;
  localparam logic [63:0] OFF_CMP  = 64'h4000;
  localparam logic [63:0] OFF_TIME = 64'hBFF8;
  localparam logic [63:0] FULL     = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        req_valid;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [63:0] req_wmask;

  clint_dev_if bus0 ();
  clint_dev_if bus1 ();

  assign bus0.req_valid = req_valid;
  assign bus0.req_wen   = req_wen;
  assign bus0.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;
  assign bus0.req_wmask = req_wmask;
  assign bus1.req_valid = req_valid;
  assign bus1.req_wen   = req_wen;
  assign bus1.req_addr  = req_addr;
  assign bus1.req_wdata = req_wdata;
  assign bus1.req_wmask = req_wmask;

  logic sw0, sw1, ti0, ti1;

  clint_dev #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut0 (
    .clock (clock), .reset (reset), .bus (bus0.slave), .sw_irq (sw0), .timer_irq (ti0)
  );
  clint_dev #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut1 (
    .clock (clock), .reset (reset), .bus (bus1.slave), .sw_irq (sw1), .timer_irq (ti1)
  );

  logic        o_hit   [2];
  logic        o_rspv  [2];
  logic [63:0] o_rdata [2];
  logic        o_sw    [2];
  logic        o_ti    [2];
  assign o_hit[0] = bus0.hit;       assign o_hit[1] = bus1.hit;
  assign o_rspv[0] = bus0.rsp_valid; assign o_rspv[1] = bus1.rsp_valid;
  assign o_rdata[0] = bus0.rsp_rdata; assign o_rdata[1] = bus1.rsp_rdata;
  assign o_sw[0] = sw0;  assign o_sw[1] = sw1;
  assign o_ti[0] = ti0;  assign o_ti[1] = ti1;

  // Reference model state per instance
  int          div    [2] = '{1, 4};
  int          ncyc   [2];
  logic        m_msip [2];
  logic [63:0] m_mtime[2];
  logic [63:0] m_cmp  [2];
  logic        m_rspv [2];
  logic [63:0] m_rdata[2];
  logic        m_irq  [2];

  int total = 0;
  int bad   = 0;

  // Advance the model by one clock using the inputs about to be sampled, then move past the edge.
  task automatic step();
    logic        hm;
    logic [15:0] off;
    logic [63:0] v;
    logic [63:0] old_time;
    logic        tk;
    hm  = req_valid && (req_addr[63:16] == BASE[63:16]);
    off = {req_addr[15:3], 3'b000};
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_msip[k] = 1'b0; m_mtime[k] = 64'd0; m_cmp[k] = FULL;
        m_rspv[k] = 1'b0; m_rdata[k] = 64'd0; m_irq[k] = 1'b0; ncyc[k] = 0;
      end else begin
        tk = ((ncyc[k] % div[k]) == (div[k] - 1));
        case (off)
          16'h0000: v = {63'd0, m_msip[k]};
          16'h4000: v = m_cmp[k];
          16'hBFF8: v = m_mtime[k];
          default:  v = 64'd0;
        endcase
        m_irq[k]  = (m_mtime[k] >= m_cmp[k]);
        m_rspv[k] = hm && !req_wen;
        if (hm && !req_wen) m_rdata[k] = v;
        old_time = m_mtime[k];
        if (tk) m_mtime[k] = m_mtime[k] + 64'd1;
        if (hm && req_wen) begin
          case (off)
            16'h0000: m_msip[k]  = (m_msip[k] & ~req_wmask[0]) | (req_wdata[0] & req_wmask[0]);
            16'h4000: m_cmp[k]   = (m_cmp[k] & ~req_wmask) | (req_wdata & req_wmask);
            16'hBFF8: m_mtime[k] = (old_time & ~req_wmask) | (req_wdata & req_wmask);
            default:  ;
          endcase
        end
        ncyc[k] = ncyc[k] + 1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic wen, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [63:0] wmask);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 64'd0; req_wdata = 64'd0; req_wmask = 64'd0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({o_rspv[k], o_sw[k], o_ti[k]} !== 3'b000) begin
        bad++; $display("FAIL reset_flags dut%0d: got %b want 000", k, {o_rspv[k], o_sw[k], o_ti[k]});
      end
      total++;
      if (o_rdata[k] !== 64'd0) begin
        bad++; $display("FAIL reset_rdata dut%0d: got %h want 0", k, o_rdata[k]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_idle_read();
    idle();
    for (int c = 0; c < 10; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (o_ti[k] !== 1'b0) begin
          bad++; $display("FAIL idle_timer dut%0d cyc%0d: got %b want 0", k, c, o_ti[k]);
        end
      end
    end
    drive(1'b0, BASE + OFF_TIME, 64'd0, 64'd0);
    #1;
    total++;
    if (o_hit[0] !== 1'b1) begin
      bad++; $display("FAIL idle_hit: got %b want 1", o_hit[0]);
    end
    step();
    idle();
    total++;
    if (o_rdata[0] !== 64'd10 || o_rspv[0] !== 1'b1) begin
      bad++; $display("FAIL idle_read_mtime dut0: got v=%b %h want v=1 10", o_rspv[0], o_rdata[0]);
    end
    total++;
    if (o_rdata[1] !== m_rdata[1] || o_rspv[1] !== 1'b1) begin
      bad++; $display("FAIL idle_read_mtime dut1: got v=%b %h want v=1 %h", o_rspv[1], o_rdata[1], m_rdata[1]);
    end
    step();
    total++;
    if (o_rspv[0] !== 1'b0 || o_rspv[1] !== 1'b0) begin
      bad++; $display("FAIL rsp_single_cycle: got %b%b want 00", o_rspv[0], o_rspv[1]);
    end
  endtask

  task automatic test_timer();
    drive(1'b1, BASE + OFF_CMP, 64'd20, FULL);
    step();
    idle();
    for (int c = 0; c < 40; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (o_ti[k] !== m_irq[k]) begin
          bad++; $display("FAIL timer_rise dut%0d cyc%0d: got %b want %b (mtime=%0d)", k, c, o_ti[k], m_irq[k], m_mtime[k]);
        end
      end
    end
    total++;
    if (o_ti[0] !== 1'b1) begin
      bad++; $display("FAIL timer_high dut0: got %b want 1", o_ti[0]);
    end
    drive(1'b1, BASE + OFF_CMP, 64'd1000, FULL);
    step();
    idle();
    total++;
    if (o_ti[0] !== 1'b1) begin
      bad++; $display("FAIL timer_lag dut0: got %b want 1", o_ti[0]);
    end
    step();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (o_ti[k] !== 1'b0) begin
        bad++; $display("FAIL timer_drop dut%0d: got %b want 0", k, o_ti[k]);
      end
    end
  endtask

  task automatic test_msip();
    drive(1'b1, BASE + OFF_MSIP, 64'hFFFF_FFFF, FULL);
    step();
    drive(1'b0, BASE + OFF_MSIP, 64'd0, 64'd0);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (o_sw[k] !== 1'b1) begin
        bad++; $display("FAIL msip_set dut%0d: got %b want 1", k, o_sw[k]);
      end
    end
    step();
    drive(1'b1, BASE + OFF_MSIP, 64'd0, FULL);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (o_rdata[k] !== 64'd1 || o_rspv[k] !== 1'b1) begin
        bad++; $display("FAIL msip_read dut%0d: got v=%b %h want v=1 1", k, o_rspv[k], o_rdata[k]);
      end
    end
    step();
    idle();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (o_sw[k] !== 1'b0) begin
        bad++; $display("FAIL msip_clear dut%0d: got %b want 0", k, o_sw[k]);
      end
    end
  endtask

  task automatic test_partial();
    idle();
    for (int i = 0; i < 4 && (ncyc[1] % 4) != 0; i++) step();
    drive(1'b1, BASE + OFF_TIME, 64'h1111_2222_3333_4444, FULL);
    step();
    drive(1'b1, BASE + OFF_TIME, 64'hAAAA_BBBB_0000_0000, 64'hFFFF_FFFF_0000_0000);
    step();
    drive(1'b0, BASE + OFF_TIME, 64'd0, 64'd0);
    step();
    idle();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (o_rdata[k] !== 64'hAAAA_BBBB_3333_4444 || o_rspv[k] !== 1'b1) begin
        bad++; $display("FAIL partial_write dut%0d: got v=%b %h want v=1 aaaabbbb33334444", k, o_rspv[k], o_rdata[k]);
      end
    end
  endtask

  task automatic test_wrap_collision();
    drive(1'b1, BASE + OFF_TIME, FULL, FULL);
    step();
    drive(1'b0, BASE + OFF_TIME, 64'd0, 64'd0);
    for (int c = 0; c < 6; c++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (o_rdata[k] !== m_rdata[k] || o_ti[k] !== m_irq[k]) begin
          bad++; $display("FAIL wrap_seq dut%0d rd%0d: got %h ti=%b want %h ti=%b", k, c, o_rdata[k], o_ti[k], m_rdata[k], m_irq[k]);
        end
      end
      if (c == 0) begin
        total++;
        if (o_rdata[0] !== FULL) begin
          bad++; $display("FAIL wrap_allones dut0: got %h want ffffffffffffffff", o_rdata[0]);
        end
      end
      if (c == 1) begin
        total++;
        if (o_rdata[0] !== 64'd0) begin
          bad++; $display("FAIL wrap_zero dut0: got %h want 0", o_rdata[0]);
        end
      end
    end
    idle();
    for (int i = 0; i < 4 && (ncyc[1] % 4) != 3; i++) step();
    drive(1'b1, BASE + OFF_TIME, 64'd5, FULL);
    step();
    drive(1'b0, BASE + OFF_TIME, 64'd0, 64'd0);
    step();
    idle();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (o_rdata[k] !== 64'd5) begin
        bad++; $display("FAIL tick_collision dut%0d: got %h want 5", k, o_rdata[k]);
      end
    end
  endtask

  task automatic test_decode();
    drive(1'b0, BASE + 64'h1000, 64'd0, 64'd0);
    step();
    drive(1'b1, BASE + 64'h1_4000, 64'd0, FULL);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (o_rdata[k] !== 64'd0 || o_rspv[k] !== 1'b1) begin
        bad++; $display("FAIL decode_hole dut%0d: got v=%b %h want v=1 0", k, o_rspv[k], o_rdata[k]);
      end
    end
    total++;
    if (o_hit[0] !== 1'b0) begin
      bad++; $display("FAIL decode_outside_wr_hit: got %b want 0", o_hit[0]);
    end
    step();
    drive(1'b0, BASE + 64'h1_0000, 64'd0, 64'd0);
    #1;
    total++;
    if (o_hit[1] !== 1'b0) begin
      bad++; $display("FAIL decode_outside_rd_hit: got %b want 0", o_hit[1]);
    end
    step();
    drive(1'b0, BASE + OFF_CMP, 64'd0, 64'd0);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (o_rspv[k] !== 1'b0) begin
        bad++; $display("FAIL decode_outside_rsp dut%0d: got %b want 0", k, o_rspv[k]);
      end
    end
    step();
    idle();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (o_rdata[k] !== 64'd1000) begin
        bad++; $display("FAIL decode_no_alias dut%0d: got %h want 3e8", k, o_rdata[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, BASE + OFF_MSIP, 64'd1, FULL);
    step();
    drive(1'b1, BASE + OFF_CMP, 64'd0, FULL);
    step();
    step();
    drive(1'b0, BASE + OFF_TIME, 64'd0, 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({o_rspv[k], o_sw[k], o_ti[k]} !== 3'b000) begin
        bad++; $display("FAIL mid_reset dut%0d: got %b want 000", k, {o_rspv[k], o_sw[k], o_ti[k]});
      end
    end
    for (int c = 0; c < 3; c++) step();
    drive(1'b0, BASE + OFF_CMP, 64'd0, 64'd0);
    step();
    idle();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (o_rdata[k] !== FULL) begin
        bad++; $display("FAIL mid_reset_cmp dut%0d: got %h want all-ones", k, o_rdata[k]);
      end
    end
  endtask

  task automatic test_random();
    int          r;
    logic [63:0] a;
    logic [63:0] d;
    logic [63:0] m;
    logic        exp_hit;
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: a = BASE + OFF_MSIP;
        1: a = BASE + OFF_CMP;
        2: a = BASE + OFF_TIME;
        3: a = BASE + 64'($urandom_range(0, 65535));
        4: a = BASE + ({32'd0, ($urandom | 32'd1)} << 16) + 64'($urandom_range(0, 65535));
        default: a = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 3))
        0: d = 64'($urandom_range(0, 600));
        1: d = FULL - 64'($urandom_range(0, 8));
        default: d = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 3))
        0: m = 64'd0;
        1: m = {$urandom, $urandom};
        default: m = FULL;
      endcase
      if ($urandom_range(0, 3) == 0) idle();
      else drive(1'($urandom_range(0, 1)), a, d, m);
      #1;
      exp_hit = req_valid && (req_addr[63:16] == BASE[63:16]);
      total++;
      if (o_hit[0] !== exp_hit || o_hit[1] !== exp_hit) begin
        bad++; $display("FAIL rand_hit cyc%0d: got %b%b want %b addr=%h", c, o_hit[0], o_hit[1], exp_hit, req_addr);
      end
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (o_rspv[k] !== m_rspv[k] || (m_rspv[k] && o_rdata[k] !== m_rdata[k]) ||
            o_sw[k] !== m_msip[k] || o_ti[k] !== m_irq[k]) begin
          bad++;
          $display("FAIL rand_state dut%0d cyc%0d: got v=%b d=%h sw=%b ti=%b want v=%b d=%h sw=%b ti=%b",
                   k, c, o_rspv[k], o_rdata[k], o_sw[k], o_ti[k], m_rspv[k], m_rdata[k], m_msip[k], m_irq[k]);
        end
      end
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_idle_read();
    test_timer();
    test_msip();
    test_partial();
    test_wrap_collision();
    test_decode();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
